// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (read-only) and data (read/write)
// share one memory with a fixed read latency. Reads occupy the memory until
// the data returns; writes complete in the accept cycle. When both ports
// request in the same cycle, the port that did not win last time is granted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | memory free; requests are granted and accepted this cycle
// ST_BUSY | read in flight; counter runs down, data returns at count 0
module mem_arbiter #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // instruction-fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // data port
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  // memory side
  output logic [31:0] mem_rd_addr_o,
  input  logic [31:0] mem_rd_data_i,
  output logic [31:0] mem_wr_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        mem_wr_enable_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // The counter is loaded with latency-1 so that count 0 lands exactly on
  // the data-return cycle.
  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_d_q;   // 1: most recent accept went to the data port
  logic        owner_d_q;  // 1: read in flight belongs to the data port
  logic [31:0] rd_addr_q;

  logic        idle;
  logic        if_gnt;
  logic        d_gnt;
  logic        rd_accept;
  logic        rd_done;
  logic [31:0] accept_addr;

  // Arbitration; reset is folded in so grants drop the moment reset asserts.
  always_comb begin
    idle        = reset_i && (state_q == ST_IDLE);
    if_gnt      = idle && if_req_i && (!d_req_i || last_d_q);
    d_gnt       = idle && d_req_i && (!if_req_i || !last_d_q);
    rd_accept   = if_gnt || (d_gnt && !d_we_i);
    accept_addr = if_gnt ? if_addr_i : d_addr_i;
    rd_done     = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  end

  // Sequencing of reads, latency countdown and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      last_d_q  <= 1'b0;
      owner_d_q <= 1'b0;
      rd_addr_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_gnt || d_gnt) begin
            last_d_q <= d_gnt;
          end
          if (rd_accept) begin
            state_q   <= ST_BUSY;
            cnt_q     <= CNT_LOAD;
            rd_addr_q <= accept_addr;
            owner_d_q <= d_gnt;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= 32'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; every data bus reads zero whenever its strobe is low.
  always_comb begin
    if_gnt_o        = if_gnt;
    d_gnt_o         = d_gnt;

    if (rd_accept) begin
      mem_rd_addr_o = accept_addr;
    end else if (state_q == ST_BUSY) begin
      mem_rd_addr_o = rd_addr_q;
    end else begin
      mem_rd_addr_o = 32'd0;
    end

    if_rvalid_o     = rd_done && !owner_d_q;
    d_rvalid_o      = rd_done && owner_d_q;
    if_rdata_o      = (rd_done && !owner_d_q) ? mem_rd_data_i : 32'd0;
    d_rdata_o       = (rd_done && owner_d_q) ? mem_rd_data_i : 32'd0;

    mem_wr_enable_o = d_gnt && d_we_i;
    mem_wr_addr_o   = (d_gnt && d_we_i) ? d_addr_i : 32'd0;
    mem_wr_data_o   = (d_gnt && d_we_i) ? d_wdata_i : 32'd0;
  end

endmodule
